// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - pipeline freeze/flush/stall control with SRAM access sequencing
module pipeline_control_unit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Hazard_detected_signal,
    input  logic             Branch_taken,
    input  logic             Mem_R_EN,
    input  logic             Mem_W_EN,
    input  logic             Sram_ready,
    output logic             Freeze_IF,
    output logic             Freeze_ID,
    output logic             Freeze_all,
    output logic             Flush_IF_ID,
    output logic             Bubble_ID_EXE,
    output logic             Sram_start,
    output logic             Sram_error,
    output logic [CNT_W-1:0] Stall_cycles
);

    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;
    logic              err_set;
    logic [CNT_W-1:0]  stall_q;
    logic              req;

    assign req = Mem_R_EN | Mem_W_EN;

    // Memory freeze outranks branch flush, which outranks the load-use stall.
    // Branches seen during MEM_WAIT are left for the first RUN cycle after release.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        err_set       = 1'b0;
        Freeze_IF     = 1'b0;
        Freeze_ID     = 1'b0;
        Freeze_all    = 1'b0;
        Flush_IF_ID   = 1'b0;
        Bubble_ID_EXE = 1'b0;
        Sram_start    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (req) begin
                        Sram_start = 1'b1;
                        Freeze_IF  = 1'b1;
                        Freeze_ID  = 1'b1;
                        Freeze_all = 1'b1;
                        wait_d     = '0;
                        state_d    = MEM_WAIT;
                    end else if (Branch_taken) begin
                        Flush_IF_ID   = 1'b1;
                        Bubble_ID_EXE = 1'b1;
                    end else if (Hazard_detected_signal) begin
                        Freeze_IF     = 1'b1;
                        Freeze_ID     = 1'b1;
                        Bubble_ID_EXE = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (Sram_ready) begin
                        state_d = RUN;
                    end else if (wait_q >= WAIT_W'(TIMEOUT)) begin
                        err_set = 1'b1;
                        state_d = RUN;
                    end else begin
                        Freeze_IF  = 1'b1;
                        Freeze_ID  = 1'b1;
                        Freeze_all = 1'b1;
                        wait_d     = wait_q + WAIT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_q | err_set;
            if (Freeze_IF && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign Sram_error   = err_q & ~rst;
    assign Stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - directed self-checking bench for pipeline_control_unit
module tb_pipeline_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        haz, br, mr, mw, rdy;
    logic        f_if, f_id, f_all, flush, bubble, start, err;
    logic [15:0] stall;
    logic        s_f_if, s_f_id, s_f_all, s_flush, s_bubble, s_start, s_err;
    logic [3:0]  s_stall;
    logic [6:0]  outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_control_unit dut (
        .clk(clk), .rst(rst),
        .Hazard_detected_signal(haz), .Branch_taken(br),
        .Mem_R_EN(mr), .Mem_W_EN(mw), .Sram_ready(rdy),
        .Freeze_IF(f_if), .Freeze_ID(f_id), .Freeze_all(f_all),
        .Flush_IF_ID(flush), .Bubble_ID_EXE(bubble),
        .Sram_start(start), .Sram_error(err), .Stall_cycles(stall)
    );

    pipeline_control_unit #(.TIMEOUT(15), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .Hazard_detected_signal(haz), .Branch_taken(br),
        .Mem_R_EN(mr), .Mem_W_EN(mw), .Sram_ready(rdy),
        .Freeze_IF(s_f_if), .Freeze_ID(s_f_id), .Freeze_all(s_f_all),
        .Flush_IF_ID(s_flush), .Bubble_ID_EXE(s_bubble),
        .Sram_start(s_start), .Sram_error(s_err), .Stall_cycles(s_stall)
    );

    // {Freeze_IF, Freeze_ID, Freeze_all, Flush_IF_ID, Bubble_ID_EXE, Sram_start, Sram_error}
    assign outs = {f_if, f_id, f_all, flush, bubble, start, err};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic b, input logic r, input logic w, input logic y);
        haz = h; br = b; mr = r; mw = w; rdy = y;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1, 1, 1, 1, 1);
        sample();
        check("rst_outs_zero", 32'(outs), 32'h0);
        cyc();
        sample();
        check("rst_outs_zero2", 32'(outs), 32'h0);
        check("rst_stall", 32'(stall), 32'd0);

        // load-use stall
        do_reset();
        set_in(1, 0, 0, 0, 0);
        sample();
        check("loaduse_outs", 32'(outs), 32'b1100100);
        cyc();
        set_in(0, 0, 0, 0, 0);
        sample();
        check("loaduse_stall", 32'(stall), 32'd1);
        check("loaduse_idle", 32'(outs), 32'h0);

        // SRAM read, ready on the 5th MEM_WAIT cycle
        do_reset();
        set_in(0, 0, 1, 0, 0);
        sample();
        check("read_start", 32'(outs), 32'b1110010);
        cyc();
        for (int i = 0; i < 4; i++) begin
            sample();
            check("read_wait", 32'(outs), 32'b1110000);
            cyc();
        end
        set_in(0, 0, 1, 0, 1);
        sample();
        check("read_release", 32'(outs), 32'h0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        sample();
        check("read_stall", 32'(stall), 32'd5);
        check("read_idle", 32'(outs), 32'h0);

        // branch wins over load-use hazard
        do_reset();
        set_in(1, 1, 0, 0, 0);
        sample();
        check("branch_haz", 32'(outs), 32'b0001100);
        cyc();
        set_in(0, 0, 0, 0, 0);
        sample();
        check("branch_haz_stall", 32'(stall), 32'd0);

        // memory freeze wins over hazard
        do_reset();
        set_in(1, 0, 0, 1, 0);
        sample();
        check("store_haz", 32'(outs), 32'b1110010);
        cyc();
        set_in(0, 0, 0, 1, 1);
        sample();
        check("store_release", 32'(outs), 32'h0);
        cyc();

        // branch held during a 3-cycle MEM_WAIT
        do_reset();
        set_in(0, 1, 1, 0, 0);
        sample();
        check("brwait_start", 32'(outs), 32'b1110010);
        cyc();
        for (int i = 0; i < 2; i++) begin
            sample();
            check("brwait_hold", 32'(outs), 32'b1110000);
            cyc();
        end
        set_in(0, 1, 1, 0, 1);
        sample();
        check("brwait_release", 32'(outs), 32'h0);
        cyc();
        set_in(0, 1, 0, 0, 0);
        sample();
        check("brwait_flush", 32'(outs), 32'b0001100);
        cyc();

        // back-to-back accesses
        do_reset();
        set_in(0, 0, 1, 0, 0);
        cyc();
        set_in(0, 0, 1, 0, 1);
        sample();
        check("b2b_release", 32'(outs), 32'h0);
        cyc();
        set_in(0, 0, 1, 0, 0);
        sample();
        check("b2b_restart", 32'(outs), 32'b1110010);
        cyc();
        set_in(0, 0, 0, 0, 1);
        cyc();

        // timeout
        do_reset();
        set_in(0, 0, 1, 0, 0);
        cyc();
        for (int i = 0; i < 15; i++) begin
            sample();
            check("to_hold", 32'(outs), 32'b1110000);
            cyc();
        end
        sample();
        check("to_release", 32'(outs), 32'h0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        sample();
        check("to_error", 32'(outs), 32'b0000001);
        check("to_stall", 32'(stall), 32'd16);
        cyc();
        sample();
        check("to_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        sample();
        check("to_rst_gate", 32'(err), 32'd0);
        cyc();
        rst = 1'b0;
        sample();
        check("to_cleared", 32'(err), 32'd0);

        // reset mid-wait aborts the access
        do_reset();
        set_in(0, 0, 1, 0, 0);
        cyc();
        cyc();
        rst = 1'b1;
        sample();
        check("abort_rst_outs", 32'(outs), 32'h0);
        cyc();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        sample();
        check("abort_run", 32'(outs), 32'h0);
        cyc();
        sample();
        check("abort_nostart", 32'(start), 32'd0);

        // stall counter saturation
        do_reset();
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc();
        set_in(0, 0, 0, 0, 0);
        sample();
        check("sat_w4", 32'(s_stall), 32'd15);
        check("sat_w16", 32'(stall), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of MEM_WAIT cycles before the unit aborts an SRAM access.
REQ-002 SHALL have parameter CNT_W, default 16, the width of Stall_cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port Hazard_detected_signal, input, 1, load-use stall request from the hazard unit (same cycle).
REQ-006 SHALL have port Branch_taken, input, 1, branch resolved taken in EXE.
REQ-007 SHALL have port Mem_R_EN, input, 1, MEM-stage load request.
REQ-008 SHALL have port Mem_W_EN, input, 1, MEM-stage store request.
REQ-009 SHALL have port Sram_ready, input, 1, SRAM access complete.
REQ-010 SHALL have port Freeze_IF, output, 1, hold PC and IF/ID.
REQ-011 SHALL have port Freeze_ID, output, 1, hold the ID stage.
REQ-012 SHALL have port Freeze_all, output, 1, hold ID/EXE, EXE/MEM and MEM/WB.
REQ-013 SHALL have port Flush_IF_ID, output, 1, clear IF/ID.
REQ-014 SHALL have port Bubble_ID_EXE, output, 1, load a NOP into ID/EXE.
REQ-015 SHALL have port Sram_start, output, 1, one-cycle access launch pulse.
REQ-016 SHALL have port Sram_error, output, 1, sticky timeout flag.
REQ-017 SHALL have port Stall_cycles, output, CNT_W, saturating stall-cycle count.

Function
REQ-018 SHALL implement FSM states RUN and MEM_WAIT, registered.
REQ-019 SHALL define Req = Mem_R_EN | Mem_W_EN.
REQ-020 In RUN with Req=1, SHALL pulse Sram_start for exactly that cycle, assert Freeze_all/Freeze_IF/Freeze_ID, and next state MEM_WAIT.
REQ-021 In MEM_WAIT, SHALL keep Freeze_all/Freeze_IF/Freeze_ID high while Sram_ready=0 and the wait counter < TIMEOUT.
REQ-022 In MEM_WAIT with Sram_ready=1, SHALL deassert all freezes that same cycle and next state RUN; Sram_start SHALL NOT re-pulse in that cycle.
REQ-023 The wait counter SHALL clear on entry to MEM_WAIT, increment each MEM_WAIT cycle, and trigger on reaching TIMEOUT without Sram_ready: Sram_error set (sticky until rst), freezes released that cycle, next state RUN.
REQ-024 In RUN with Req=0 and Branch_taken=1, SHALL assert Flush_IF_ID and Bubble_ID_EXE, with Freeze_IF=Freeze_ID=0 even if Hazard_detected_signal=1.
REQ-025 In RUN with Req=0, Branch_taken=0 and Hazard_detected_signal=1, SHALL assert Freeze_IF, Freeze_ID and Bubble_ID_EXE, with Freeze_all=0.
REQ-026 While Freeze_all=1, Flush_IF_ID and Bubble_ID_EXE SHALL be 0; a pending branch is acted on when released.
REQ-027 Priority SHALL be memory freeze > branch flush > load-use stall.
REQ-028 Stall_cycles SHALL increment by 1 on each cycle with Freeze_IF=1, and saturate at 2^CNT_W-1 (no wrap).
REQ-029 Back-to-back requests SHALL be allowed: a Req seen in RUN the cycle after release starts a new access.

Reset
REQ-030 With rst=1 at a clock edge, SHALL set state RUN, wait counter 0, Sram_error 0 and Stall_cycles 0.
REQ-031 While rst=1, all 1-bit outputs SHALL be 0 regardless of inputs.
REQ-032 rst asserted mid-MEM_WAIT SHALL abort the access with no Sram_start pulse after release.

Verification
REQ-033 Load-use: RUN, Hazard=1 for 1 cycle -> Freeze_IF=Freeze_ID=Bubble_ID_EXE=1 that cycle, Freeze_all=0, Stall_cycles 0->1.
REQ-034 SRAM read: Mem_R_EN=1, Sram_ready after 4 MEM_WAIT cycles -> Sram_start one cycle, Freeze_all high 5 cycles, low on the ready cycle, Stall_cycles=5.
REQ-035 Branch with hazard: Branch_taken=1 and Hazard=1 in RUN -> Flush_IF_ID=Bubble_ID_EXE=1, Freeze_IF=0.
REQ-036 Branch during wait: Branch_taken=1 throughout a 3-cycle MEM_WAIT -> Flush_IF_ID=0 until release, 1 on the first RUN cycle after.
REQ-037 Timeout: TIMEOUT=15, Sram_ready never -> Sram_error=1 after 15 MEM_WAIT cycles, freezes drop, state RUN; rst clears it.
REQ-038 Saturation: CNT_W=4, freeze 20 cycles -> Stall_cycles holds at 15.
